// File: rtl/image_scan_controller.sv
// Raster-scan sequencer and ROM address arbiter: streams a full frame with row/col
// tags and shares the ROM address port with a random-access requester.
module image_scan_controller #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int RA_BURST_MAX = 4
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  rom_row,
  output logic [8:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [11:0] pixel_out,
  output logic [7:0]  pix_row,
  output logic [8:0]  pix_col,
  output logic        pix_last,
  input  logic        ra_req,
  input  logic [7:0]  ra_row,
  input  logic [8:0]  ra_col,
  output logic        ra_ack,
  output logic [11:0] ra_data
);

  localparam logic [7:0] LAST_ROW = 8'(IMAGE_HEIGHT - 1);
  localparam logic [8:0] LAST_COL = 9'(IMAGE_WIDTH - 1);
  localparam int FAIR_W = $clog2(RA_BURST_MAX + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(RA_BURST_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t            state;
  logic [7:0]        scan_row, last_row;
  logic [8:0]        scan_col, last_col;
  logic [FAIR_W-1:0] fair_cnt;
  logic              scan_want, ra_grant, scan_issue, at_last, handshake;

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    rom_row    = last_row;
    rom_col    = last_col;
    scan_want  = (state == SCAN) && (!pix_valid || pix_ready);
    // Gating with Reset_n keeps the address port at zero for the whole reset.
    ra_grant   = Reset_n && ra_req && !(scan_want && (fair_cnt >= FAIR_MAX));
    scan_issue = scan_want && !ra_grant;
    at_last    = (scan_row == LAST_ROW) && (scan_col == LAST_COL);
    handshake  = pix_valid && pix_ready;
    if (ra_grant) begin
      rom_row = ra_row;
      rom_col = ra_col;
    end else if (scan_issue) begin
      rom_row = scan_row;
      rom_col = scan_col;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      scan_row   <= '0;
      scan_col   <= '0;
      last_row   <= '0;
      last_col   <= '0;
      fair_cnt   <= '0;
      frame_done <= 1'b0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      pixel_out  <= '0;
      pix_row    <= '0;
      pix_col    <= '0;
      ra_ack     <= 1'b0;
      ra_data    <= '0;
    end else begin
      // NOTE: non-blocking only here; later assignments in this block override earlier ones.
      ra_ack     <= ra_grant;
      frame_done <= 1'b0;
      if (ra_grant) ra_data <= rom_data;
      if (ra_grant || scan_issue) begin
        last_row <= rom_row;
        last_col <= rom_col;
      end
      if (handshake) begin
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
      end

      if (abort) begin
        state     <= IDLE;
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
        fair_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            fair_cnt <= '0;
            if (start) begin
              state    <= SCAN;
              scan_row <= '0;
              scan_col <= '0;
            end
          end
          SCAN: begin
            if (scan_issue) begin
              pixel_out <= rom_data;
              pix_row   <= scan_row;
              pix_col   <= scan_col;
              pix_valid <= 1'b1;
              pix_last  <= at_last;
              fair_cnt  <= '0;
              // Counters park on the last coordinate; DRAIN waits for its handshake.
              if (at_last) begin
                state <= DRAIN;
              end else if (scan_col == LAST_COL) begin
                scan_col <= '0;
                scan_row <= scan_row + 8'd1;
              end else begin
                scan_col <= scan_col + 9'd1;
              end
            end else if (ra_grant && scan_want) begin
              fair_cnt <= fair_cnt + 1'b1;
            end
          end
          DRAIN: begin
            if (handshake) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/image_scan_controller.md
# image_scan_controller

Sequencing and arbitration controller for the image ROM. It runs full-frame raster scans on start, delivering pixels with row/col tags over a valid/ready stream. It also shares the same ROM address port with a random-access requester (the mask engine), so the ROM is never driven by two masters. It sits between `image_rom` and the downstream masking/transfer pipeline.

## Interface
- IMAGE_WIDTH, 320, pixels per row; columns 0..IMAGE_WIDTH-1
- IMAGE_HEIGHT, 240, rows per frame; rows 0..IMAGE_HEIGHT-1
- RA_BURST_MAX, 4, max consecutive random-access grants while the scan is waiting
- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame scan; honoured only in IDLE
- abort  in  1  terminate the scan immediately
- busy  out  1  high in SCAN and DRAIN
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- rom_row  out  8  ROM row address
- rom_col  out  9  ROM column address
- rom_data  in  12  ROM data, combinational from rom_row/rom_col in the same cycle
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accept
- pixel_out  out  12  pixel data
- pix_row  out  8  row of pixel_out
- pix_col  out  9  column of pixel_out
- pix_last  out  1  high with the final pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1)
- ra_req  in  1  random-access request; held until ra_ack
- ra_row  in  8  random-access row, stable while ra_req is high
- ra_col  in  9  random-access column
- ra_ack  out  1  one-cycle grant/data-valid strobe
- ra_data  out  12  random-access data, valid while ra_ack is high

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE -> SCAN on start. Scan counters clear to (0,0).
- SCAN -> DRAIN on the edge that issues (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
- DRAIN -> IDLE on the handshake of the pix_last beat. frame_done pulses on the following cycle.
- Any state -> IDLE on abort. abort beats start when both are high together. start is ignored while busy.
- A scan issue is wanted when the state is SCAN and the output slot is free: (!pix_valid || pix_ready).
- ROM address mux each cycle:
  - Grant random access if ra_req is high, unless the fairness counter has reached RA_BURST_MAX and a scan issue is wanted.
  - Otherwise drive the scan counters.
  - With neither active, hold the last address.
- Fairness counter:
  - Increments on each random-access grant made while a scan issue is wanted.
  - Clears on any scan issue, and clears in IDLE.
- Scan issue:
  - Loads rom_data, row and col into the output register; sets pix_valid; sets pix_last when the coordinate is the last one.
  - Advances col. Col wraps from IMAGE_WIDTH-1 to 0 and increments row.
  - Counters never exceed the last index.
- Output register holds all its fields unchanged while pix_valid && !pix_ready. pix_valid clears after a handshake with no new issue.
- Random-access grant: ra_data is registered from rom_data and ra_ack is high the next cycle. If ra_req is still high in the ack cycle, that is a new request (back-to-back allowed).

## Timing
- Reset values: state IDLE; counters 0; busy, frame_done, pix_valid, pix_last, ra_ack all 0; pixel_out, pix_row, pix_col, ra_data, rom_row, rom_col all 0.
- start sampled at edge N → busy high after N. First scan issue at edge N+1, so pix_valid is high from N+1.
- Throughput is one pixel per cycle with pix_ready=1 and no ra_req. A frame is IMAGE_WIDTH×IMAGE_HEIGHT beats on consecutive cycles.
- Random-access latency is 1 cycle from the granting edge to ra_ack.
- With ra_req held continuously during SCAN, the pattern is RA_BURST_MAX grants, then 1 scan issue, repeating.
- abort at edge M: pix_valid, pix_last and busy are low after M. Any pending or queued beat is discarded, and no frame_done is produced.
- An in-flight random access completes normally across abort.
- Reset_n asserted mid-operation: every output returns to its reset value asynchronously. No frame_done is produced.

## Test plan
- IMAGE_WIDTH=4, IMAGE_HEIGHT=3, pix_ready=1, start pulse → 12 beats on consecutive cycles, (0,0),(0,1)…(2,3). pix_last only on beat 12. frame_done pulses once the next cycle, then busy=0.
- Same frame with pix_ready toggling 1,0,0,1… → exactly 12 handshakes, no duplicates or gaps. pixel_out/pix_row/pix_col stay stable through every stall.
- In IDLE, ra_req with (1,2) → ra_ack high one cycle later, ra_data = ROM[1][2], scan outputs untouched.
- During SCAN, ra_req held for 10 back-to-back requests → grant pattern 4 RA, 1 scan, 4 RA, 1 scan, 2 RA, then scan resumes. The pixel sequence is still complete and ordered.
- abort at beat 5 → pix_valid=0 the next cycle, no frame_done. A following start restarts at (0,0).
- Reset_n low mid-frame → all outputs 0 immediately. After release, start yields a clean full frame. start and abort asserted together in IDLE → state stays IDLE.
